// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and defaults for the truth-table sweeper: state encoding, default
// parameters and the dwell-counter width helper.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int DEF_N_INPUTS  = 4;
    localparam int DEF_N_OUTPUTS = 1;
    localparam int DEF_DWELL     = 10;

    // Counter wide enough to hold 0..dwell inclusive.
    function automatic int dwell_w(input int dwell);
        return $clog2(dwell + 1);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while enabled and flags the final cycle of each
// dwell window with a one-cycle last pulse.
module dwell_timer
    import sweep_pkg::*;
#(
    parameter int DWELL = DEF_DWELL,
    parameter int CNT_W = dwell_w(DEF_DWELL)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = enable && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector, compares DUT outputs
// with a golden table. Define SWEEP_STOP_ON_FAIL_EN to halt on the first mismatch.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_DRIVE | holding vec_out for DWELL cycles, compare on the last one
// ST_DONE  | all vectors swept, results held until start
// ST_HALT  | stopped at first mismatch (SWEEP_STOP_ON_FAIL_EN only)
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_INPUTS  = DEF_N_INPUTS,
    parameter int N_OUTPUTS = DEF_N_OUTPUTS,
    parameter int DWELL     = DEF_DWELL
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [(2**N_INPUTS)*N_OUTPUTS-1:0]   expected,
    input  logic [N_OUTPUTS-1:0]                 dut_out,
    output logic [N_INPUTS-1:0]                  vec_out,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 pass,
    output logic [N_INPUTS:0]                    err_count,
    output logic                                 fail_valid,
    output logic [N_INPUTS-1:0]                  first_fail_idx
);

    localparam int                N_VEC   = 2**N_INPUTS;
    localparam logic [N_INPUTS-1:0] VEC_MAX = {N_INPUTS{1'b1}};

    state_e                state_q, state_d;
    logic [N_INPUTS-1:0]   vec_q, vec_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [N_INPUTS:0]     err_q, err_d;
    logic                  fail_valid_q, fail_valid_d;
    logic [N_INPUTS-1:0]   first_q, first_d;

    logic                  last;
    logic [N_OUTPUTS-1:0]  exp_slice;
    logic                  mismatch;

    dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (dwell_w(DWELL))
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_DRIVE),
        .enable (state_q == ST_DRIVE),
        .last   (last)
    );

    always_comb begin
        exp_slice = '0;
        for (int v = 0; v < N_VEC; v++) begin
            if (vec_q == N_INPUTS'(v)) begin
                exp_slice = expected[v*N_OUTPUTS +: N_OUTPUTS];
            end
        end
    end

    assign mismatch = (dut_out != exp_slice);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        first_d      = first_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_HALT: begin
                if (start) begin
                    state_d      = ST_DRIVE;
                    vec_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    first_d      = '0;
                end
            end
            ST_DRIVE: begin
                if (last) begin
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            first_d      = vec_q;
                        end
                    end
`ifdef SWEEP_STOP_ON_FAIL_EN
                    if (mismatch) begin
                        state_d = ST_HALT;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                    end else
`endif
                    if (vec_q == VEC_MAX) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_q      <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            first_q      <= first_d;
        end
    end

    assign vec_out        = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_idx = first_q;

endmodule
